// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE 16-bit datapath.
// Holds the ALU opcode constants, the instruction format codes, the
// operand-fetch FSM state type and the writeback-enable decode helper.
package simple_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_NOP = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_ROL = 4'd11;
  localparam logic [3:0] OP_IN  = 4'd12;
  localparam logic [3:0] OP_OUT = 4'd13;
  localparam logic [3:0] OP_RSV = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam logic [1:0] FMT_ARITH = 2'b11;
  localparam logic [1:0] FMT_LI    = 2'b10;

  typedef enum logic {RUN, HALT} fsm_t;

  // Result is written back for every arithmetic op except the ones that
  // only set flags, produce output, or do nothing.
  function automatic logic wr_en_of(input logic [3:0] op3);
    logic en;
    case (op3)
      OP_CMP, OP_NOP, OP_OUT, OP_RSV, OP_HLT: en = 1'b0;
      default:                                en = 1'b1;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/simple_regfile.sv
// Register file for the SIMPLE datapath.
// Ports: clk, rst (async, active-high, clears all registers);
//   ra_addr/ra_data, rb_addr/rb_data: combinational read ports;
//   wb_en/wb_addr/wb_data: synchronous write port.
// A read of the address being written in the same cycle returns wb_data.
module simple_regfile #(
  parameter int NREG = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREG)-1:0]  ra_addr,
  output logic [15:0]              ra_data,
  input  logic [$clog2(NREG)-1:0]  rb_addr,
  output logic [15:0]              rb_data,
  input  logic                     wb_en,
  input  logic [$clog2(NREG)-1:0]  wb_addr,
  input  logic [15:0]              wb_data
);

  logic [15:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign ra_data = (wb_en && (wb_addr == ra_addr)) ? wb_data : regs[ra_addr];
  assign rb_data = (wb_en && (wb_addr == rb_addr)) ? wb_data : regs[rb_addr];

endmodule

// File: rtl/operand_fetch.sv
// Decode and operand-fetch stage of the SIMPLE datapath, feeding the ALU.
// Ports: clk, rst (async, active-high);
//   instr/instr_valid/instr_ready: instruction handshake;
//   wb_en/wb_addr/wb_data: register-file writeback from downstream;
//   out_valid/out_ready: operand latch handshake;
//   out_in1, out_in2, out_opcode, out_rd, out_wr_en: issued operands;
//   halted: HLT has issued (left only through rst).
module operand_fetch
  import simple_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic                     wb_en,
  input  logic [$clog2(NREG)-1:0]  wb_addr,
  input  logic [15:0]              wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_in1,
  output logic [15:0]              out_in2,
  output logic [3:0]               out_opcode,
  output logic [$clog2(NREG)-1:0]  out_rd,
  output logic                     out_wr_en,
  output logic                     halted
);

  localparam int AW = $clog2(NREG);

  fsm_t state;

  logic [1:0]    fmt;
  logic [AW-1:0] rs, rd;
  logic [3:0]    op3, d4;
  logic [7:0]    d8;
  logic          is_arith, is_li;
  logic          a_from_rs;
  logic [AW-1:0] ra_addr, rb_addr;
  logic [15:0]   ra_data, rb_data;
  logic          use_a, use_b;
  logic          d_issue, d_hlt, d_wr;
  logic [15:0]   d_in1, d_in2;
  logic [3:0]    d_op;
  logic          hazard, accept;

  assign fmt      = instr[15:14];
  assign rs       = instr[11 +: AW];
  assign rd       = instr[8 +: AW];
  assign op3      = instr[7:4];
  assign d4       = instr[3:0];
  assign d8       = instr[7:0];
  assign is_arith = (fmt == FMT_ARITH);
  assign is_li    = (fmt == FMT_LI) && (instr[13:11] == 3'b000);

  // Port A carries rd for two-operand and shift ops, but rs for MOV/OUT.
  assign a_from_rs = is_arith && ((op3 == OP_MOV) || (op3 == OP_OUT));
  assign ra_addr   = a_from_rs ? rs : rd;
  assign rb_addr   = rs;

  simple_regfile #(.NREG(NREG)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (ra_addr),
    .ra_data (ra_data),
    .rb_addr (rb_addr),
    .rb_data (rb_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  // Which register ports the decoded word really reads; immediates and
  // unused fields must not raise the interlock.
  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    if (is_arith) begin
      case (op3)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
          use_a = 1'b1;
          use_b = 1'b1;
        end
        OP_MOV, OP_OUT, OP_SLL, OP_SRL, OP_SRA, OP_ROL: use_a = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    d_in1   = '0;
    d_in2   = '0;
    d_op    = op3;
    d_wr    = 1'b0;
    d_issue = 1'b0;
    d_hlt   = 1'b0;
    if (is_arith) begin
      d_wr    = wr_en_of(op3);
      d_hlt   = (op3 == OP_HLT);
      d_issue = !d_hlt;
      if (use_a) d_in1 = ra_data;
      if (use_b) d_in2 = rb_data;
      if (op3 inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL}) d_in2 = {12'b0, d4};
    end else if (is_li) begin
      d_op    = OP_MOV;
      d_in1   = {{8{d8[7]}}, d8};
      d_wr    = 1'b1;
      d_issue = 1'b1;
    end
  end

  assign hazard = out_valid && out_wr_en &&
                  ((use_a && (ra_addr == out_rd)) || (use_b && (rb_addr == out_rd)));

  assign instr_ready = (state == RUN) && !hazard && (!out_valid || out_ready);
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      halted     <= 1'b0;
      out_valid  <= 1'b0;
      out_in1    <= '0;
      out_in2    <= '0;
      out_opcode <= '0;
      out_rd     <= '0;
      out_wr_en  <= 1'b0;
    end else begin
      if (accept) begin
        // Bubbles and HLT are consumed without occupying the latch.
        out_valid <= d_issue;
        if (d_issue) begin
          out_in1    <= d_in1;
          out_in2    <= d_in2;
          out_opcode <= d_op;
          out_rd     <= rd;
          out_wr_en  <= d_wr;
        end
        if (d_hlt) begin
          state  <= HALT;
          halted <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  typedef struct packed {
    logic [15:0] in1;
    logic [15:0] in2;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic        wr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_in1, out_in2;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rd;
  logic        out_wr_en;
  logic        halted;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  logic [15:0] mreg [8];
  bit          auto_wb = 1'b1;
  bit          pend = 1'b0;
  logic [2:0]  pend_a = '0;
  logic [15:0] pend_d = '0;
  exp_t        mon_e;
  bit          mon_iss;

  operand_fetch #(.NREG(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_in1     (out_in1),
    .out_in2     (out_in2),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_wr_en   (out_wr_en),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [2:0] rs, input logic [2:0] rd,
                                      input logic [3:0] op, input logic [3:0] d4);
    return {2'b11, rs, rd, op, d4};
  endfunction

  // Reference decode against the bench's own register model.
  function automatic void predict(input logic [15:0] w, output bit issue, output exp_t e);
    logic [2:0] rs, rd;
    logic [3:0] op, d4;
    logic [7:0] d8;
    rs = w[13:11]; rd = w[10:8]; op = w[7:4]; d4 = w[3:0]; d8 = w[7:0];
    e = '0;
    issue = 1'b0;
    if (w[15:14] == 2'b11) begin
      e.op = op;
      e.rd = rd;
      if (op <= 4'd5) begin
        e.in1 = mreg[rd];
        e.in2 = mreg[rs];
      end else if (op == 4'd6 || op == 4'd13) begin
        e.in1 = mreg[rs];
      end else if (op >= 4'd8 && op <= 4'd11) begin
        e.in1 = mreg[rd];
        e.in2 = {12'b0, d4};
      end
      e.wr  = (op <= 4'd4) || (op == 4'd6) || (op >= 4'd8 && op <= 4'd12);
      issue = (op != 4'd15);
    end else if (w[15:14] == 2'b10 && w[13:11] == 3'b000) begin
      e.in1 = {{8{d8[7]}}, d8};
      e.op  = 4'd6;
      e.rd  = rd;
      e.wr  = 1'b1;
      issue = 1'b1;
    end
  endfunction

  // Pretend ALU/writeback: result = in1 + in2, written one cycle after transfer.
  always @(posedge clk) begin
    #1;
    if (auto_wb) begin
      wb_en   = pend;
      wb_addr = pend_a;
      wb_data = pend_d;
      pend    = 1'b0;
    end
  end

  // Scoreboard: push on accept, pop and compare on transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got in1=%h in2=%h op=%0d rd=%0d wr=%b, expected nothing",
                   out_in1, out_in2, out_opcode, out_rd, out_wr_en);
        end else begin
          mon_e = sb.pop_front();
          if ({out_in1, out_in2, out_opcode, out_rd, out_wr_en} !== mon_e) begin
            errors++;
            $display("FAIL sb_issue: got in1=%h in2=%h op=%0d rd=%0d wr=%b, expected in1=%h in2=%h op=%0d rd=%0d wr=%b",
                     out_in1, out_in2, out_opcode, out_rd, out_wr_en,
                     mon_e.in1, mon_e.in2, mon_e.op, mon_e.rd, mon_e.wr);
          end
          if (auto_wb && mon_e.wr) begin
            pend   = 1'b1;
            pend_a = mon_e.rd;
            pend_d = mon_e.in1 + mon_e.in2;
          end
        end
      end
      // Applying the write before decoding matches the write-through bypass.
      if (wb_en) mreg[wb_addr] = wb_data;
      if (instr_valid && instr_ready) begin
        predict(instr, mon_iss, mon_e);
        if (mon_iss) sb.push_back(mon_e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    @(posedge clk); #1;
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!instr_ready) begin
      errors++;
      $display("FAIL send_timeout: instr %h not accepted within 50 cycles", w);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    sb.delete();
    pend = 1'b0;
    instr_valid = 1'b0;
    #3;
  endtask

  task automatic release_reset;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({out_valid, halted} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%b halted=%b, expected 0 0", out_valid, halted);
    end
    checks++;
    if ({out_in1, out_in2, out_opcode, out_rd, out_wr_en} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outs: in1=%h in2=%h op=%0d rd=%0d wr=%b, expected all 0",
               out_in1, out_in2, out_opcode, out_rd, out_wr_en);
    end
    release_reset();
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: instr_ready=%b, expected 1", instr_ready);
    end
  endtask

  task automatic test_li_add;
    out_ready = 1'b1;
    @(posedge clk); #1;
    instr = 16'h81FD;                      // LI r1, -3
    instr_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL li_ready: instr_ready=%b, expected 1", instr_ready);
    end
    @(posedge clk); #1;
    instr = enc(3'd1, 3'd2, 4'd0, 4'd0);   // ADD r2 <- r2 + r1
    @(negedge clk);
    checks++;
    if ({out_in1, out_opcode, out_rd} !== {16'hFFFD, 4'd6, 3'd1}) begin
      errors++;
      $display("FAIL li_issue: in1=%h op=%0d rd=%0d, expected fffd 6 1", out_in1, out_opcode, out_rd);
    end
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL raw_stall: instr_ready=%b, expected 0", instr_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_release: instr_ready=%b, expected 1", instr_ready);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_in2, out_opcode, out_rd} !== {1'b1, 16'hFFFD, 4'd0, 3'd2}) begin
      errors++;
      $display("FAIL add_issue: valid=%b in2=%h op=%0d rd=%0d, expected 1 fffd 0 2",
               out_valid, out_in2, out_opcode, out_rd);
    end
  endtask

  task automatic test_shift_cmp;
    send(enc(3'd0, 3'd4, 4'd8, 4'd5));     // SLL r4, 5
    @(negedge clk);
    checks++;
    if ({out_valid, out_in2, out_opcode, out_wr_en} !== {1'b1, 16'h0005, 4'd8, 1'b1}) begin
      errors++;
      $display("FAIL sll_issue: valid=%b in2=%h op=%0d wr=%b, expected 1 0005 8 1",
               out_valid, out_in2, out_opcode, out_wr_en);
    end
    send(enc(3'd2, 3'd1, 4'd5, 4'd0));     // CMP r1, r2
    @(negedge clk);
    checks++;
    if ({out_valid, out_opcode, out_wr_en} !== {1'b1, 4'd5, 1'b0}) begin
      errors++;
      $display("FAIL cmp_issue: valid=%b op=%0d wr=%b, expected 1 5 0", out_valid, out_opcode, out_wr_en);
    end
  endtask

  task automatic test_bypass;
    auto_wb = 1'b0;
    @(posedge clk); #1;
    instr = enc(3'd0, 3'd3, 4'd1, 4'd0);   // SUB rd=3, rs=0
    instr_valid = 1'b1;
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL bypass_ready: instr_ready=%b, expected 1", instr_ready);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    wb_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_in1, out_opcode} !== {16'h1234, 4'd1}) begin
      errors++;
      $display("FAIL bypass_in1: in1=%h op=%0d, expected 1234 1", out_in1, out_opcode);
    end
    idle(2);
    auto_wb = 1'b1;
  endtask

  task automatic test_backpressure;
    logic [15:0] exp_a;
    exp_a = mreg[1];
    out_ready = 1'b0;
    @(posedge clk); #1;
    instr = enc(3'd1, 3'd5, 4'd6, 4'd0);   // MOV r5 <- r1
    instr_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_ready: instr_ready=%b, expected 1", instr_ready);
    end
    @(posedge clk); #1;
    instr = enc(3'd2, 3'd6, 4'd0, 4'd0);   // ADD r6 <- r6 + r2
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, instr_ready, out_in1, out_rd} !== {1'b1, 1'b0, exp_a, 3'd5}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid=%b ready=%b in1=%h rd=%0d, expected 1 0 %h 5",
                 c, out_valid, instr_ready, out_in1, out_rd, exp_a);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: instr_ready=%b, expected 1", instr_ready);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    idle(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: %0d entries left, expected 0", sb.size());
    end
  endtask

  task automatic test_bubble;
    send(16'h0000);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bubble_valid: out_valid=%b, expected 0", out_valid);
    end
    send(16'h8705);                        // LI r7, 5
    @(negedge clk);
    checks++;
    if ({out_valid, out_in1, out_opcode, out_rd} !== {1'b1, 16'h0005, 4'd6, 3'd7}) begin
      errors++;
      $display("FAIL bubble_next: valid=%b in1=%h op=%0d rd=%0d, expected 1 0005 6 7",
               out_valid, out_in1, out_opcode, out_rd);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send(enc(3'd1, 3'd2, 4'd6, 4'd0));     // MOV r2 <- r1, left in the latch
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b, expected 0", out_valid);
    end
    out_ready = 1'b1;
    release_reset();
  endtask

  task automatic test_halt;
    auto_wb = 1'b0;
    send(enc(3'd0, 3'd0, 4'd15, 4'd0));    // HLT
    @(negedge clk);
    checks++;
    if ({halted, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL halt_state: halted=%b out_valid=%b, expected 1 0", halted, out_valid);
    end
    @(posedge clk); #1;
    instr = enc(3'd1, 3'd2, 4'd0, 4'd0);
    instr_valid = 1'b1;
    wb_en = 1'b1; wb_addr = 3'd6; wb_data = 16'hABCD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({instr_ready, halted} !== 2'b01) begin
        errors++;
        $display("FAIL halt_ready: cycle %0d instr_ready=%b halted=%b, expected 0 1", c, instr_ready, halted);
      end
      @(posedge clk); #1;
      wb_en = 1'b0;
    end
    instr_valid = 1'b0;
    do_reset();
    checks++;
    if ({halted, out_valid, out_in1, out_in2, out_opcode, out_rd, out_wr_en} !== 42'd0) begin
      errors++;
      $display("FAIL halt_reset: halted=%b out_valid=%b in1=%h in2=%h op=%0d, expected all 0",
               halted, out_valid, out_in1, out_in2, out_opcode);
    end
    release_reset();
    auto_wb = 1'b1;
    send(enc(3'd6, 3'd0, 4'd6, 4'd0));     // MOV r0 <- r6, r6 cleared by reset
    @(negedge clk);
    checks++;
    if ({out_valid, out_in1, out_opcode} !== {1'b1, 16'h0000, 4'd6}) begin
      errors++;
      $display("FAIL post_reset_mov: valid=%b in1=%h op=%0d, expected 1 0000 6", out_valid, out_in1, out_opcode);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    test_reset();
    test_li_add();
    idle(3);
    test_shift_cmp();
    idle(3);
    test_bypass();
    idle(2);
    test_backpressure();
    idle(2);
    test_bubble();
    idle(3);
    test_reset_mid();
    idle(2);
    test_halt();
    idle(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
